rf_port_ctrl: RTL and testbench
===============================

Name: rf_port_ctrl

Overview:
- Initiator side of the frisc register-file interface; sits between issue/decode and `regfile`.
- Drives the regfile read indices (`rin1`/`rin2`) and the single write port (`write_en`/`rd`/`data`).
- Holds a 32-entry pending-write scoreboard to stall RAW/WAW hazards.
- Arbitrates ALU and load writebacks onto the one write port, forwards same-cycle writeback data, and registers fetched operands behind a valid/ready handshake.

Parameters:
- XLEN, 32, data width; must match `regfile`.
- NREGS, 32, architectural register count.
- AW, 5, register index width, $clog2(NREGS).
- LD_PRIO, 1, 1 = load writeback wins arbitration, 0 = ALU wins.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- iss_valid  in  1  issue request
- iss_ready  out  1  issue accepted when valid&ready
- iss_rs1  in  AW  source 1 index
- iss_rs2  in  AW  source 2 index
- iss_rd  in  AW  destination index
- iss_rd_wen  in  1  instruction writes rd
- op_valid  out  1  operand bundle valid
- op_ready  in  1  consumer accepts bundle
- op_rs1_data  out  XLEN  operand 1
- op_rs2_data  out  XLEN  operand 2
- op_rd  out  AW  destination carried along
- op_rd_wen  out  1  destination write flag carried along
- alu_wb_valid  in  1  ALU writeback request
- alu_wb_ready  out  1  ALU writeback granted
- alu_wb_rd  in  AW  ALU destination
- alu_wb_data  in  XLEN  ALU result
- ld_wb_valid  in  1  load writeback request
- ld_wb_ready  out  1  load writeback granted
- ld_wb_rd  in  AW  load destination
- ld_wb_data  in  XLEN  load data
- rf_rin1  out  AW  to regfile `rin1` = iss_rs1
- rf_rin2  out  AW  to regfile `rin2` = iss_rs2
- rf_rs1  in  XLEN  from regfile `rs1`, combinational read
- rf_rs2  in  XLEN  from regfile `rs2`, combinational read
- rf_write_en  out  1  to regfile `write_en`
- rf_rd  out  AW  to regfile `rd`
- rf_data  out  XLEN  to regfile `data`

Behaviour:
- **Reset values:**
  - Scoreboard all zero.
  - op_valid=0; op_rs1_data/op_rs2_data/op_rd/op_rd_wen=0.
  - iss_ready=0, alu_wb_ready=0, ld_wb_ready=0, rf_write_en=0 while reset is high.
  - Reset mid-operation drops any held bundle. Writebacks presented during reset are not granted.
- **Writeback arbitration (combinational, same cycle):**
  - Winner = LD_PRIO ? load : ALU when both are valid.
  - Winner ready=1; loser ready=0 and must hold its request.
  - A lone requester is always granted.
  - Grant → rf_rd=wb_rd, rf_data=wb_data, rf_write_en=(wb_rd!=0); the regfile commits at the next posedge.
  - No grant → rf_write_en=0, rf_rd=0, rf_data=0.
- **Scoreboard pend[NREGS]; pend[0] is always 0:**
  - Clear: pend[rf_rd] on a granted writeback.
  - Set: pend[iss_rd] on issue accept with iss_rd_wen and iss_rd!=0.
  - Same index set and cleared in one cycle → set wins.
- **Hazard, per source s in {rs1, rs2}:**
  - haz_s = pend[s] and not (grant and rf_rd==s).
  - waw = iss_rd_wen and pend[iss_rd] and not (grant and rf_rd==iss_rd).
- **Issue handshake:**
  - iss_ready = !reset & (!op_valid | op_ready) & !haz_rs1 & !haz_rs2 & !waw.
  - iss_ready is independent of iss_valid.
- **Operand fetch:**
  - On accept, capture into the op_* registers; op_valid=1 on the next cycle (latency 1).
  - Operand value per source:
    - index 0 → 0;
    - else grant and rf_rd==index → winning wb data (bypass);
    - else rf_rsX.
- **Operand handshake:**
  - op_valid clears on op_ready without a new accept.
  - Back-to-back accept/consume gives full throughput.
  - op_* are stable while op_valid & !op_ready.
- **Writebacks to x0:** the handshake completes, but nothing is written and the scoreboard is unchanged.

Decomposition:
- **Package `frisc_rf_pkg`:** AW, XLEN, NREGS constants; typedef `reg_idx_t` (logic [AW-1:0]); typedef `xdata_t`; struct `wb_req_t` {valid, rd, data}.
- **Sub-module `wb_arbiter`:** two-request fixed-priority arbiter. Output is the grant plus the selected `wb_req_t`.
- **Top:** scoreboard, hazard/bypass logic and the operand register.

Test Plan:
1. **Reset, no writes:** reset 2 cycles, then issue rs1=3, rs2=4, rd=5 → iss_ready=1; next cycle op_valid=1 with operands 0,0; pend[5]=1.
2. **RAW stall then bypass:** issue rd=5, then issue rs1=5 → iss_ready=0 until ALU wb rd=5, data=32'hDEADBEEF. In that wb cycle iss_ready=1 and op_rs1_data=32'hDEADBEEF next cycle; regfile holds the value one cycle later.
3. **Arbitration:** ALU and load both valid (rd=7/8, data 1/2), LD_PRIO=1 → ld_wb_ready=1, alu_wb_ready=0, rf_rd=8. Next cycle ALU granted, rf_rd=7. Repeat with LD_PRIO=0 → order reversed.
4. **x0 handling:** load wb rd=0, data=5 → ld_wb_ready=1, rf_write_en=0; a later issue rs1=0 gives operand 0; issue rd=0 with wen → no stall on subsequent rd=0.
5. **Backpressure:** op_ready=0 with op_valid=1 → iss_ready=0 and op_* unchanged for 4 cycles. op_ready=1 with a pending issue → new bundle next cycle, no gap.
6. **Reset mid-op:** pend[9]=1 and op_valid=1, assert reset 1 cycle → op_valid=0, pend all 0; issue rs1=9 accepted immediately after.

Source files
------------

// File: rtl/frisc_rf_pkg.sv
// rtl/frisc_rf_pkg.sv - shared widths and writeback request type for the frisc register-file port
package frisc_rf_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xdata_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        xdata_t   data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - fixed-priority arbiter between ALU and load writebacks
module wb_arbiter
    import frisc_rf_pkg::*;
#(
    parameter int LD_PRIO = 1
) (
    input  wb_req_t i_alu,
    input  wb_req_t i_ld,
    output logic    o_alu_grant,
    output logic    o_ld_grant,
    output wb_req_t o_sel
);

    localparam logic LdWins = (LD_PRIO != 0);

    always_comb begin
        o_alu_grant = i_alu.valid & (~i_ld.valid | ~LdWins);
        o_ld_grant  = i_ld.valid  & (~i_alu.valid | LdWins);
        o_sel       = '0;
        if (o_ld_grant) begin
            o_sel = i_ld;
        end else if (o_alu_grant) begin
            o_sel = i_alu;
        end
    end

endmodule

// File: rtl/rf_port_ctrl.sv
// rtl/rf_port_ctrl.sv - register-file initiator: scoreboard, writeback port, bypass and operand register
module rf_port_ctrl
    import frisc_rf_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int LD_PRIO = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_rd_wen,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] op_rs1_data,
    output logic [XLEN-1:0] op_rs2_data,
    output logic [AW-1:0]   op_rd,
    output logic            op_rd_wen,
    input  logic            alu_wb_valid,
    output logic            alu_wb_ready,
    input  logic [AW-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic            ld_wb_valid,
    output logic            ld_wb_ready,
    input  logic [AW-1:0]   ld_wb_rd,
    input  logic [XLEN-1:0] ld_wb_data,
    output logic [AW-1:0]   rf_rin1,
    output logic [AW-1:0]   rf_rin2,
    input  logic [XLEN-1:0] rf_rs1,
    input  logic [XLEN-1:0] rf_rs2,
    output logic            rf_write_en,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_data
);

    wb_req_t          w_alu_req;
    wb_req_t          w_ld_req;
    wb_req_t          w_win;
    logic             w_alu_grant;
    logic             w_ld_grant;
    logic             w_grant;
    logic             w_haz_rs1;
    logic             w_haz_rs2;
    logic             w_waw;
    logic             w_accept;
    logic [NREGS-1:0] w_pend_nxt;
    logic [XLEN-1:0]  w_opnd1;
    logic [XLEN-1:0]  w_opnd2;

    logic [NREGS-1:0] r_pend;
    logic             r_op_valid;
    logic [XLEN-1:0]  r_op_rs1_data;
    logic [XLEN-1:0]  r_op_rs2_data;
    logic [AW-1:0]    r_op_rd;
    logic             r_op_rd_wen;

    // Requests are masked during reset so nothing is granted or written back.
    assign w_alu_req = '{valid: alu_wb_valid & ~reset, rd: alu_wb_rd, data: alu_wb_data};
    assign w_ld_req  = '{valid: ld_wb_valid & ~reset, rd: ld_wb_rd, data: ld_wb_data};

    wb_arbiter #(
        .LD_PRIO (LD_PRIO)
    ) u_wb_arbiter (
        .i_alu       (w_alu_req),
        .i_ld        (w_ld_req),
        .o_alu_grant (w_alu_grant),
        .o_ld_grant  (w_ld_grant),
        .o_sel       (w_win)
    );

    assign w_grant      = w_win.valid;
    assign alu_wb_ready = w_alu_grant;
    assign ld_wb_ready  = w_ld_grant;
    assign rf_write_en  = w_grant & (w_win.rd != '0);
    assign rf_rd        = w_grant ? w_win.rd : '0;
    assign rf_data      = w_grant ? w_win.data : '0;
    assign rf_rin1      = iss_rs1;
    assign rf_rin2      = iss_rs2;

    // A register being written back this cycle is no longer a hazard.
    assign w_haz_rs1 = r_pend[iss_rs1] & ~(w_grant & (w_win.rd == iss_rs1));
    assign w_haz_rs2 = r_pend[iss_rs2] & ~(w_grant & (w_win.rd == iss_rs2));
    assign w_waw     = iss_rd_wen & r_pend[iss_rd] & ~(w_grant & (w_win.rd == iss_rd));

    assign iss_ready = ~reset & (~r_op_valid | op_ready) & ~w_haz_rs1 & ~w_haz_rs2 & ~w_waw;
    assign w_accept  = iss_valid & iss_ready;

    always_comb begin
        w_opnd1 = rf_rs1;
        if (iss_rs1 == '0) begin
            w_opnd1 = '0;
        end else if (w_grant && (w_win.rd == iss_rs1)) begin
            w_opnd1 = w_win.data;
        end
        w_opnd2 = rf_rs2;
        if (iss_rs2 == '0) begin
            w_opnd2 = '0;
        end else if (w_grant && (w_win.rd == iss_rs2)) begin
            w_opnd2 = w_win.data;
        end
    end

    // Set is applied after clear so a same-index collision leaves the bit pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_grant) begin
            w_pend_nxt[w_win.rd] = 1'b0;
        end
        if (w_accept && iss_rd_wen && (iss_rd != '0)) begin
            w_pend_nxt[iss_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend        <= '0;
            r_op_valid    <= 1'b0;
            r_op_rs1_data <= '0;
            r_op_rs2_data <= '0;
            r_op_rd       <= '0;
            r_op_rd_wen   <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_accept) begin
                r_op_valid    <= 1'b1;
                r_op_rs1_data <= w_opnd1;
                r_op_rs2_data <= w_opnd2;
                r_op_rd       <= iss_rd;
                r_op_rd_wen   <= iss_rd_wen;
            end else if (op_ready) begin
                r_op_valid <= 1'b0;
            end
        end
    end

    assign op_valid    = r_op_valid;
    assign op_rs1_data = r_op_rs1_data;
    assign op_rs2_data = r_op_rs2_data;
    assign op_rd       = r_op_rd;
    assign op_rd_wen   = r_op_rd_wen;

endmodule

// File: tb/tb_rf_port_ctrl.sv
// tb/tb_rf_port_ctrl.sv - directed self-checking bench for rf_port_ctrl
module tb_rf_port_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rf_clr = 1'b1;
    logic        iss_valid = 1'b0, iss_rd_wen = 1'b0, op_ready = 1'b1;
    logic [4:0]  iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
    logic        alu_wb_valid = 1'b0, ld_wb_valid = 1'b0;
    logic [4:0]  alu_wb_rd = '0, ld_wb_rd = '0;
    logic [31:0] alu_wb_data = '0, ld_wb_data = '0;
    logic        iss_ready, op_valid, op_rd_wen, alu_wb_ready, ld_wb_ready, rf_write_en;
    logic [31:0] op_rs1_data, op_rs2_data, rf_rs1, rf_rs2, rf_data;
    logic [4:0]  op_rd, rf_rin1, rf_rin2, rf_rd;
    logic [31:0] rf_mem [32];

    logic        alu0_valid = 1'b0, ld0_valid = 1'b0;
    logic [4:0]  alu0_rd = '0, ld0_rd = '0;
    logic [31:0] alu0_data = '0, ld0_data = '0;
    logic        d0_iss_ready, d0_op_valid, d0_op_rd_wen, alu0_ready, ld0_ready, d0_rf_we;
    logic [31:0] d0_op1, d0_op2, d0_rf_data;
    logic [4:0]  d0_op_rd, d0_rin1, d0_rin2, d0_rf_rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (rf_write_en) begin
            rf_mem[rf_rd] <= rf_data;
        end
    end
    assign rf_rs1 = rf_mem[rf_rin1];
    assign rf_rs2 = rf_mem[rf_rin2];

    rf_port_ctrl #(.XLEN(32), .NREGS(32), .AW(5), .LD_PRIO(1)) dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_rd_wen(iss_rd_wen),
        .op_valid(op_valid), .op_ready(op_ready), .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
        .op_rd(op_rd), .op_rd_wen(op_rd_wen),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .ld_wb_valid(ld_wb_valid), .ld_wb_ready(ld_wb_ready), .ld_wb_rd(ld_wb_rd), .ld_wb_data(ld_wb_data),
        .rf_rin1(rf_rin1), .rf_rin2(rf_rin2), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_write_en(rf_write_en), .rf_rd(rf_rd), .rf_data(rf_data)
    );

    rf_port_ctrl #(.XLEN(32), .NREGS(32), .AW(5), .LD_PRIO(0)) dut0 (
        .clk(clk), .reset(reset),
        .iss_valid(1'b0), .iss_ready(d0_iss_ready), .iss_rs1(5'd0), .iss_rs2(5'd0),
        .iss_rd(5'd0), .iss_rd_wen(1'b0),
        .op_valid(d0_op_valid), .op_ready(1'b1), .op_rs1_data(d0_op1), .op_rs2_data(d0_op2),
        .op_rd(d0_op_rd), .op_rd_wen(d0_op_rd_wen),
        .alu_wb_valid(alu0_valid), .alu_wb_ready(alu0_ready), .alu_wb_rd(alu0_rd), .alu_wb_data(alu0_data),
        .ld_wb_valid(ld0_valid), .ld_wb_ready(ld0_ready), .ld_wb_rd(ld0_rd), .ld_wb_data(ld0_data),
        .rf_rin1(d0_rin1), .rf_rin2(d0_rin2), .rf_rs1(32'd0), .rf_rs2(32'd0),
        .rf_write_en(d0_rf_we), .rf_rd(d0_rf_rd), .rf_data(d0_rf_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iss(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d, input logic w);
        iss_valid = v; iss_rs1 = s1; iss_rs2 = s2; iss_rd = d; iss_rd_wen = w;
    endtask

    task automatic test_reset();
        set_iss(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; ld_wb_valid = 1'b1; ld_wb_rd = 5'd4;
        #1;
        tests++; if (iss_ready !== 1'b0) begin fails++; $display("FAIL rst_iss_ready: got %b want 0", iss_ready); end
        tests++; if (alu_wb_ready !== 1'b0) begin fails++; $display("FAIL rst_alu_ready: got %b want 0", alu_wb_ready); end
        tests++; if (ld_wb_ready !== 1'b0) begin fails++; $display("FAIL rst_ld_ready: got %b want 0", ld_wb_ready); end
        tests++; if (rf_write_en !== 1'b0) begin fails++; $display("FAIL rst_rf_we: got %b want 0", rf_write_en); end
        step(); step();
        reset = 1'b0; rf_clr = 1'b0;
        alu_wb_valid = 1'b0; ld_wb_valid = 1'b0;
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        tests++; if (op_valid !== 1'b0) begin fails++; $display("FAIL rst_op_valid: got %b want 0", op_valid); end
        tests++; if ({op_rs1_data, op_rs2_data, op_rd, op_rd_wen} !== 70'd0) begin fails++; $display("FAIL rst_op_regs: got %h %h %h %b want 0", op_rs1_data, op_rs2_data, op_rd, op_rd_wen); end
    endtask

    task automatic test_raw_bypass();
        set_iss(1'b1, 5'd3, 5'd4, 5'd5, 1'b1);
        #1;
        tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL basic_iss_ready: got %b want 1", iss_ready); end
        step();
        tests++; if (op_valid !== 1'b1) begin fails++; $display("FAIL basic_op_valid: got %b want 1", op_valid); end
        tests++; if ({op_rs1_data, op_rs2_data} !== 64'd0) begin fails++; $display("FAIL basic_operands: got %h %h want 0 0", op_rs1_data, op_rs2_data); end
        tests++; if (op_rd !== 5'd5 || op_rd_wen !== 1'b1) begin fails++; $display("FAIL basic_rd: got %0d/%b want 5/1", op_rd, op_rd_wen); end
        set_iss(1'b1, 5'd5, 5'd0, 5'd6, 1'b0);
        #1;
        tests++; if (iss_ready !== 1'b0) begin fails++; $display("FAIL raw_stall0: got %b want 0", iss_ready); end
        step();
        tests++; if (iss_ready !== 1'b0) begin fails++; $display("FAIL raw_stall1: got %b want 0", iss_ready); end
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
        #1;
        tests++; if (alu_wb_ready !== 1'b1) begin fails++; $display("FAIL raw_alu_ready: got %b want 1", alu_wb_ready); end
        tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL raw_release: got %b want 1", iss_ready); end
        tests++; if (rf_write_en !== 1'b1 || rf_rd !== 5'd5) begin fails++; $display("FAIL raw_rf_port: got %b/%0d want 1/5", rf_write_en, rf_rd); end
        step();
        alu_wb_valid = 1'b0;
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tests++; if (op_rs1_data !== 32'hDEADBEEF) begin fails++; $display("FAIL raw_bypass: got %h want deadbeef", op_rs1_data); end
        tests++; if (op_rd !== 5'd6 || op_rd_wen !== 1'b0) begin fails++; $display("FAIL raw_rd: got %0d/%b want 6/0", op_rd, op_rd_wen); end
        tests++; if (rf_mem[5] !== 32'hDEADBEEF) begin fails++; $display("FAIL raw_regfile: got %h want deadbeef", rf_mem[5]); end
    endtask

    task automatic test_arbitration();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'd1;
        ld_wb_valid = 1'b1; ld_wb_rd = 5'd8; ld_wb_data = 32'd2;
        alu0_valid = 1'b1; alu0_rd = 5'd7; alu0_data = 32'd1;
        ld0_valid = 1'b1; ld0_rd = 5'd8; ld0_data = 32'd2;
        #1;
        tests++; if ({ld_wb_ready, alu_wb_ready} !== 2'b10) begin fails++; $display("FAIL arb1_ready: got ld=%b alu=%b want ld=1 alu=0", ld_wb_ready, alu_wb_ready); end
        tests++; if (rf_rd !== 5'd8 || rf_data !== 32'd2) begin fails++; $display("FAIL arb1_first: got %0d/%0d want 8/2", rf_rd, rf_data); end
        tests++; if ({ld0_ready, alu0_ready} !== 2'b01) begin fails++; $display("FAIL arb0_ready: got ld=%b alu=%b want ld=0 alu=1", ld0_ready, alu0_ready); end
        tests++; if (d0_rf_rd !== 5'd7 || d0_rf_data !== 32'd1) begin fails++; $display("FAIL arb0_first: got %0d/%0d want 7/1", d0_rf_rd, d0_rf_data); end
        step();
        ld_wb_valid = 1'b0; alu0_valid = 1'b0;
        #1;
        tests++; if (alu_wb_ready !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'd1) begin fails++; $display("FAIL arb1_second: got rdy=%b %0d/%0d want 1 7/1", alu_wb_ready, rf_rd, rf_data); end
        tests++; if (ld0_ready !== 1'b1 || d0_rf_rd !== 5'd8 || d0_rf_data !== 32'd2) begin fails++; $display("FAIL arb0_second: got rdy=%b %0d/%0d want 1 8/2", ld0_ready, d0_rf_rd, d0_rf_data); end
        step();
        alu_wb_valid = 1'b0; ld0_valid = 1'b0;
        #1;
        tests++; if (rf_write_en !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'd0) begin fails++; $display("FAIL idle_port: got %b/%0d/%h want 0/0/0", rf_write_en, rf_rd, rf_data); end
    endtask

    task automatic test_x0();
        ld_wb_valid = 1'b1; ld_wb_rd = 5'd0; ld_wb_data = 32'd5;
        set_iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        tests++; if (ld_wb_ready !== 1'b1 || rf_write_en !== 1'b0) begin fails++; $display("FAIL x0_wb: got rdy=%b we=%b want 1/0", ld_wb_ready, rf_write_en); end
        tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL x0_iss1: got %b want 1", iss_ready); end
        step();
        ld_wb_valid = 1'b0;
        tests++; if (op_rs1_data !== 32'd0 || op_rd !== 5'd0 || op_rd_wen !== 1'b1) begin fails++; $display("FAIL x0_operand: got %h rd=%0d/%b want 0 0/1", op_rs1_data, op_rd, op_rd_wen); end
        #1;
        tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL x0_no_waw: got %b want 1", iss_ready); end
        step();
        set_iss(1'b1, 5'd5, 5'd9, 5'd0, 1'b0);
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd9; alu_wb_data = 32'h1234;
        #1;
        tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL byp2_iss: got %b want 1", iss_ready); end
        step();
        alu_wb_valid = 1'b0;
        tests++; if (op_rs1_data !== 32'hDEADBEEF || op_rs2_data !== 32'h1234) begin fails++; $display("FAIL byp2_operands: got %h %h want deadbeef 1234", op_rs1_data, op_rs2_data); end
    endtask

    task automatic test_backpressure();
        set_iss(1'b1, 5'd5, 5'd0, 5'd10, 1'b1);
        step();
        tests++; if (op_rd !== 5'd10 || op_rs1_data !== 32'hDEADBEEF) begin fails++; $display("FAIL bp_setup: got %0d/%h want 10/deadbeef", op_rd, op_rs1_data); end
        op_ready = 1'b0;
        set_iss(1'b1, 5'd3, 5'd4, 5'd11, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++; if (iss_ready !== 1'b0) begin fails++; $display("FAIL bp_iss_ready[%0d]: got %b want 0", c, iss_ready); end
            tests++; if (op_valid !== 1'b1 || op_rd !== 5'd10 || op_rs1_data !== 32'hDEADBEEF) begin fails++; $display("FAIL bp_hold[%0d]: got %b %0d %h want 1 10 deadbeef", c, op_valid, op_rd, op_rs1_data); end
            step();
        end
        op_ready = 1'b1;
        #1;
        tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got %b want 1", iss_ready); end
        step();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tests++; if (op_valid !== 1'b1 || op_rd !== 5'd11) begin fails++; $display("FAIL bp_next: got %b/%0d want 1/11", op_valid, op_rd); end
        step();
        tests++; if (op_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b want 0", op_valid); end
    endtask

    task automatic test_reset_mid();
        set_iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        step();
        set_iss(1'b0, 5'd9, 5'd0, 5'd0, 1'b0);
        #1;
        tests++; if (op_valid !== 1'b1 || iss_ready !== 1'b0) begin fails++; $display("FAIL mid_setup: got v=%b rdy=%b want 1/0", op_valid, iss_ready); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests++; if (op_valid !== 1'b0 || op_rd !== 5'd0) begin fails++; $display("FAIL mid_dropped: got %b/%0d want 0/0", op_valid, op_rd); end
        set_iss(1'b1, 5'd9, 5'd10, 5'd11, 1'b1);
        #1;
        tests++; if (iss_ready !== 1'b1) begin fails++; $display("FAIL mid_pend_clear: got %b want 1", iss_ready); end
        step();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tests++; if (op_valid !== 1'b1 || op_rd !== 5'd11 || op_rs1_data !== 32'h1234 || op_rs2_data !== 32'd0) begin fails++; $display("FAIL mid_reissue: got %b %0d %h %h want 1 11 1234 0", op_valid, op_rd, op_rs1_data, op_rs2_data); end
    endtask

    initial begin
        #1;
        test_reset();
        test_raw_bypass();
        test_arbitration();
        test_x0();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
